// File: rtl/i2c_pkg.sv
// Shared definitions for the BMP180-style I2C register responder:
// FSM encoding, ACK levels and the emulated device constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] BMP180_ADDR     = 7'h77;
  localparam logic [7:0] BMP180_ID       = 8'h55;
  localparam logic [7:0] BMP180_ID_REG   = 8'hD0;
  localparam logic [7:0] BMP180_REG_BASE = 8'hF4;

  // Pointers below the base wrap to a large offset, so one compare covers both sides.
  function automatic logic in_window(input logic [7:0] ptr, input logic [7:0] base,
                                     input logic [7:0] count);
    logic [7:0] off;
    off = ptr - base;
    return (off < count);
  endfunction

endpackage

// File: rtl/i2c_reg_responder_if.sv
// Fabric-side report of the responder: accepted writes, activity and FSM state.
interface i2c_reg_responder_if;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] state;

  modport slave  (output wr_strobe, output wr_addr, output wr_data, output busy, output state);
  modport master (input  wr_strobe, input  wr_addr, input  wr_data, input  busy, input  state);
endinterface

// File: rtl/i2c_line_sync.sv
// Brings scl/sda into the clk domain and derives edge, START and STOP events.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl};
    sda_d = {sda_q[1:0], sda};
  end

  // Reset to the idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];
  assign sda_s     =  sda_q[1];

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target emulating a BMP180 register map: chip-ID register plus a small
// writable file, open-drain sda, every accepted data byte reported to the fabric.
module i2c_reg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = BMP180_ADDR,
  parameter logic [7:0] CHIP_ID   = BMP180_ID,
  parameter logic [7:0] ID_REG    = BMP180_ID_REG,
  parameter logic [7:0] REG_BASE  = BMP180_REG_BASE,
  parameter int         REG_COUNT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  inout  wire                   sda,
  i2c_reg_responder_if.slave    fab
);

  localparam int         IDX_W = $clog2(REG_COUNT);
  localparam logic [7:0] COUNT = 8'(REG_COUNT);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [REG_COUNT];
  logic [7:0] regs_d [REG_COUNT];

  logic [7:0]       rx_byte, win_off, rd_val;
  logic [IDX_W-1:0] win_idx;
  logic             win_hit;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign win_off = ptr_q - REG_BASE;
  assign win_idx = win_off[IDX_W-1:0];
  assign win_hit = in_window(ptr_q, REG_BASE, COUNT);
  assign rd_val  = (ptr_q == ID_REG) ? CHIP_ID : (win_hit ? regs_q[win_idx] : 8'hFF);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                rw_d    = rx_byte[0];
                busy_d  = (rx_byte[7:1] == DEV_ADDR);
                state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte;
                state_d = ST_PTR_ACK;
              end else begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = rx_byte;
                ptr_d       = ptr_q + 8'd1;
                state_d     = ST_WDATA_ACK;
                if (win_hit && (ptr_q != ID_REG)) begin
                  regs_d[win_idx] = rx_byte;
                end else begin
                  regs_d = regs_q;
                end
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        // First falling edge starts the ACK pulse, the second one ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall && !sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              shift_d  = rd_val;
              sda_oe_d = ~rd_val[7];
              ptr_d    = ptr_q + 8'd1;
              state_d  = ST_RDATA;
            end else begin
              state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RDATA: begin
          if (scl_fall && bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RDATA_ACK;
          end else if (scl_fall) begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && sda_s == NACK) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = ST_IGNORE;
          end else if (scl_fall) begin
            shift_d   = rd_val;
            sda_oe_d  = ~rd_val[7];
            ptr_d     = ptr_q + 8'd1;
            bit_cnt_d = 3'd0;
            state_d   = ST_RDATA;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // All responder state registers; reset also clears the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      ptr_q       <= 8'd0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  // Gating with reset lets sda go high-Z in the very cycle reset is raised.
  assign sda = (sda_oe_q && !reset) ? 1'b0 : 1'bz;

  assign fab.wr_strobe = wr_strobe_q;
  assign fab.wr_addr   = wr_addr_q;
  assign fab.wr_data   = wr_data_q;
  assign fab.busy      = busy_q;
  assign fab.state     = state_q;

endmodule

// File: doc/i2c_reg_responder.md
Name: i2c_reg_responder

Overview:
- I2C target (responder) emulating a BMP180-style register device; answers the master driver's chip-ID and register transactions in-system, without the real sensor.
- Samples external scl/sda on the system clock, decodes START/STOP/address/data, drives ACK and read data open-drain on sda.
- Holds a small writable register file plus a read-only chip-ID register; reports every accepted write to the fabric.

Parameters:
- DEV_ADDR, 7'h77, 7-bit device address answered.
- CHIP_ID, 8'h55, value returned at ID_REG.
- ID_REG, 8'hD0, register pointer of the read-only chip-ID register.
- REG_BASE, 8'hF4, first pointer of the writable register file.
- REG_COUNT, 8, number of writable bytes (power of two, 2..16).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock from master; no clock stretching.
- sda  inout  1  I2C data; driven only to 0, otherwise high-Z.
- wr_strobe  output  1  one-cycle pulse per accepted data byte written.
- wr_addr  output  8  register pointer of that write.
- wr_data  output  8  data byte of that write.
- busy  output  1  high from addressed START until STOP or NACK release.
- state  output  4  current FSM state code (debug/LEDs).

Behaviour:
- Reset: sda released, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, pointer=0, register file cleared to 0. Reset mid-transfer releases sda within the same cycle and abandons the transaction.
- Input conditioning: scl, sda pass through a 2-flop synchroniser and a 3rd stage for edge detection; all decisions use synchronised values (latency 3 clk, under 1/8 of scl period at 100 kHz with clk ≥ 10 MHz).
- START: sda falls while scl high → enter ADDR from any state, clear bit counter. STOP: sda rises while scl high → IDLE from any state, release sda, busy=0.
- Bits sampled on scl rising edge, MSB first; sda changes only on scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: after 8 bits compare [7:1] to DEV_ADDR. Mismatch → IGNORE (sda never driven until next START/STOP). Match → ADDR_ACK, busy=1; bit0=0 selects write path, bit0=1 read path.
- ACK drive: pull sda low from the scl falling edge after bit 8 until the scl falling edge after the 9th clock.
- Write path: first byte after ADDR_ACK → PTR (pointer loaded), PTR_ACK; following bytes → WDATA, WDATA_ACK; each WDATA byte acked, written at pointer if pointer in [REG_BASE, REG_BASE+REG_COUNT-1], wr_strobe pulsed one cycle at the 8th rising scl edge with wr_addr=pointer, wr_data=byte (pulsed for all pointers, incl. ID_REG/unmapped), pointer+1.
- Writes to ID_REG or unmapped pointers: acked, storage unchanged.
- Read path: on falling scl ending ADDR_ACK load shift register with value at pointer (ID_REG → CHIP_ID; mapped → file; else 8'hFF), drive bits MSB first (0 → pull low, 1 → release). Pointer+1 after each byte.
- RDATA_ACK: sample master bit on 9th rising edge; ACK(0) → next RDATA; NACK(1) → IGNORE, sda released, busy=0.
- Pointer arithmetic: 8-bit, wraps 8'hFF→8'h00; no wrap inside file window. Pointer retained across STOP, so read after repeated START reads last set pointer.
- Repeated START mid-byte: byte discarded, no strobe.
- Simultaneous START and reset: reset wins.

Decomposition:
- Package i2c_pkg: FSM state encoding (4-bit), ACK/NACK constants, BMP180 constants (address 7'h77, ID 8'h55, ID reg 8'hD0).
- Sub-module i2c_line_sync: synchroniser + edge detect, outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- START, 0xEE, 0xD0, repeated START, 0xEF, master NACK → ACKs on both addresses and pointer, read byte 0x55, sda released after NACK, busy=0.
- START, 0xEE, 0xF4, 0xA5, 0x3C, STOP → wr_strobe twice: (F4,A5), (F5,3C); readback from F4 with ACK then NACK returns A5, 3C.
- START, 0xA0 (address 0x50), 0x12, STOP → sda never low, busy=0, no wr_strobe.
- Write pointer 0xFB (REG_BASE+7) then read 2 bytes → file[7] then 0xFF (0xFC unmapped); pointer now 0xFD.
- reset asserted during 5th bit of read byte → sda high-Z next cycle, state=IDLE, file cleared; next 0xD0 read still returns 0x55.
- Write 0x99 to 0xD0 → ACKed, wr_strobe (D0,99), subsequent ID read still 0x55.
